irq_sched: RTL and testbench
============================

Name: irq_sched

Overview:
- Prioritised, programmable interrupt controller for the KR580 core; it replaces the fixed three-entry interrupt queue in the I/O block.
- Latches edge requests from up to 8 sources (keyboard, timer, vertical retrace, ...).
- Applies a CPU-writable mask and tracks in-service sources so that only higher-priority sources may nest.
- Signals the CPU by toggling `irq` and presenting `vector`, then waits for acceptance via `iff1` before issuing the next interrupt.

Parameters:
NSRC, 8, number of request sources (1..8); bit 0 has highest priority
BASE, 16'h00F0, I/O port of register 0; registers occupy BASE..BASE+3
GAP, 4, minimum idle clocks after acceptance before the next issue (1..15)

Ports:
clock    in   1   system clock
reset    in   1   asynchronous, active-high reset
address  in   16  CPU port address
out      in   8   CPU write data
port_we  in   1   port write strobe, one clock
port_rd  in   1   port read strobe (qualifies nothing internally; for bench visibility)
req      in   NSRC  request pulses, one clock wide per event (e.g. kdone)
iff1     in   1   CPU interrupt-enable flag; a 1->0 transition means the interrupt was accepted or disabled
irq      out  1   toggle-signalled interrupt: every change of level is one new interrupt
vector   out  4   source index + 1 of the last issued interrupt; 0 = none since reset
rdata    out  8   combinational read data for the addressed register, 8'hFF if not addressed

Behaviour:
- Reset (asynchronous, active high) sets:
  - irq=0, vector=0
  - mask=all 1s (all sources masked), pend=0, isr=0
  - state=IDLE, gap counter=0
  - Reset during any state aborts it immediately; a half-issued interrupt is lost.
- Register map (reads are combinational on address; writes take effect on the clock edge with port_we):
  - BASE+0 MASK: read/write. Bit = 1 masks the source. Bits >= NSRC read 1 and ignore writes.
  - BASE+1 PEND: read pending bits. A write clears each pend bit written as 1.
  - BASE+2 ISR: read in-service bits. A write of any value is EOI: clears the lowest-index set isr bit. EOI with isr=0 has no effect.
  - BASE+3 STAT: read {state==WAIT, gap!=0, 2'b00, vector}.
  - Unused bits read 0.
- Request capture: req[i]=1 sets pend[i] every cycle, regardless of mask or state. A repeated request while pend is already set is merged (no counting). If a req pulse and a PEND clear for the same bit fall in the same cycle, the request wins (pend stays 1).
- Candidate selection:
  - eligible[i] = pend[i] & ~mask[i] & (index i is lower than the lowest set isr bit, or isr=0).
  - The winner is the lowest eligible index.
- FSM:
  - IDLE: if iff1=1, gap=0 and any source is eligible, then in a single clock: vector<=winner+1, irq<=~irq, pend[winner]<=0, isr[winner]<=1, go to WAIT. Otherwise stay.
  - WAIT: hold irq/vector. When iff1=0 is sampled, load gap<=GAP and go to IDLE.
  - In IDLE, gap counts down by 1 per clock to 0. No issue is possible while gap!=0.
- Issue latency: a req pulse at edge N, with iff1=1, source unmasked and idle gap=0, produces the irq toggle at edge N+1 (pend is visible first at N).
- Simultaneous cases:
  - EOI and issue in the same cycle: both apply, and eligibility uses the pre-EOI isr.
  - MASK write and issue in the same cycle: the issue uses the old mask.
  - A PEND clear of the winner in the issue cycle: the issue proceeds and pend ends at 0.
- A masked source stays pending and is issued once unmasked, subject to the other conditions.

Test Plan:
1. Reset with no requests: irq=0, vector=0, MASK reads 8'hFF, PEND/ISR read 8'h00, rdata=8'hFF at address 16'h00FE.
2. MASK=8'h00, iff1=1, req[0] pulse → irq toggles 0→1 one clock later, vector=1, ISR=8'h01, PEND=0, STAT[7]=1. Then drop iff1 → state IDLE, STAT[6]=1 for 4 clocks.
3. req[2] and req[1] pulsed together, iff1=1, isr=0 → vector=2 issued first. Cycle iff1 1→0→1 without EOI: source 2 is blocked by isr[1] and irq does not toggle. Write BASE+2 (EOI) → ISR=0, then vector=3 issued.
4. MASK=8'hFE, req[3] pulse → no toggle, PEND=8'h08. Write MASK=8'h00 with iff1=1 → toggle, vector=4.
5. Same-cycle req[5] pulse and PEND write 8'h20 → PEND reads 8'h20. Assert reset while in WAIT → irq=0, vector=0, PEND=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_sched.sv
// Prioritised, maskable interrupt scheduler for the KR580 core.
// Edge requests are latched, filtered by mask and in-service nesting, and issued by toggling irq.
module irq_sched #(
  parameter int          NSRC = 8,
  parameter logic [15:0] BASE = 16'h00F0,
  parameter int          GAP  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [15:0]     address,
  input  logic [7:0]      out,
  input  logic            port_we,
  input  logic            port_rd,
  input  logic [NSRC-1:0] req,
  input  logic            iff1,
  output logic            irq,
  output logic [3:0]      vector,
  output logic [7:0]      rdata
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          r_state, w_state_next;
  logic [NSRC-1:0] r_mask, r_pend, r_isr;
  logic [NSRC-1:0] w_mask_next, w_pend_next, w_isr_next;
  logic [3:0]      r_gap, w_gap_next;
  logic            r_irq, w_irq_next;
  logic [3:0]      r_vector, w_vector_next;

  logic [15:0]     w_off;
  logic            w_hit, w_wr_mask, w_wr_pend, w_wr_isr;
  logic [NSRC-1:0] w_blocked, w_elig, w_win_oh;
  logic [2:0]      w_win;
  logic            w_any, w_issue;
  logic            w_unused;

  assign w_unused  = port_rd;
  assign w_off     = address - BASE;
  assign w_hit     = (w_off < 16'd4);
  assign w_wr_mask = port_we & w_hit & (w_off[1:0] == 2'd0);
  assign w_wr_pend = port_we & w_hit & (w_off[1:0] == 2'd1);
  assign w_wr_isr  = port_we & w_hit & (w_off[1:0] == 2'd2);

  // A source is blocked when it or any higher-priority source is in service.
  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi = gi + 1) begin : g_src
      if (gi == 0) begin : g_first
        assign w_blocked[gi] = r_isr[gi];
      end else begin : g_rest
        assign w_blocked[gi] = w_blocked[gi-1] | r_isr[gi];
      end
      assign w_win_oh[gi] = (w_win == 3'(gi));
    end
  endgenerate

  assign w_elig = r_pend & ~r_mask & ~w_blocked;
  assign w_any  = |w_elig;

  always_comb begin
    w_win = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_win = 3'(i);
    end
  end

  assign w_issue = (r_state == S_IDLE) & iff1 & (r_gap == 4'd0) & w_any;

  always_comb begin
    w_state_next  = r_state;
    w_gap_next    = r_gap;
    w_irq_next    = r_irq;
    w_vector_next = r_vector;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_next  = S_WAIT;
          w_irq_next    = ~r_irq;
          w_vector_next = {1'b0, w_win} + 4'd1;
        end else if (r_gap != 4'd0) begin
          w_gap_next = r_gap - 4'd1;
        end
      end
      S_WAIT: begin
        if (!iff1) begin
          w_gap_next   = 4'(GAP);
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_mask_next = w_wr_mask ? out[NSRC-1:0] : r_mask;
    // Requests are OR-ed last so a same-cycle clear never loses a new event.
    w_pend_next = (r_pend & ~(w_wr_pend ? out[NSRC-1:0] : '0)
                          & ~(w_issue ? w_win_oh : '0)) | req;
    // x & (x-1) drops the lowest set bit, i.e. the highest-priority in-service source.
    w_isr_next  = (w_wr_isr ? (r_isr & (r_isr - NSRC'(1))) : r_isr)
                | (w_issue ? w_win_oh : '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_gap    <= 4'd0;
      r_irq    <= 1'b0;
      r_vector <= 4'd0;
      r_mask   <= '1;
      r_pend   <= '0;
      r_isr    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_gap    <= w_gap_next;
      r_irq    <= w_irq_next;
      r_vector <= w_vector_next;
      r_mask   <= w_mask_next;
      r_pend   <= w_pend_next;
      r_isr    <= w_isr_next;
    end
  end

  always_comb begin
    rdata = 8'hFF;
    if (w_hit) begin
      case (w_off[1:0])
        2'd0:    rdata = ~8'(~r_mask);
        2'd1:    rdata = 8'(r_pend);
        2'd2:    rdata = 8'(r_isr);
        default: rdata = {(r_state == S_WAIT), (r_gap != 4'd0), 2'b00, r_vector};
      endcase
    end
  end

  assign irq    = r_irq;
  assign vector = r_vector;

endmodule

// File: tb/tb_irq_sched.sv
// Bench for irq_sched: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a behavioural model of the scheduler.
module tb_irq_sched;
  localparam int          NSRC = 8;
  localparam logic [15:0] BASE = 16'h00F0;
  localparam int          GAP  = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [15:0]     address = 16'h0000;
  logic [7:0]      out = 8'h00;
  logic            port_we = 1'b0;
  logic            port_rd = 1'b0;
  logic [NSRC-1:0] req = '0;
  logic            iff1 = 1'b0;
  logic            irq;
  logic [3:0]      vector;
  logic [7:0]      rdata;

  irq_sched #(.NSRC(NSRC), .BASE(BASE), .GAP(GAP)) dut (
    .clock(clock), .reset(reset), .address(address), .out(out),
    .port_we(port_we), .port_rd(port_rd), .req(req), .iff1(iff1),
    .irq(irq), .vector(vector), .rdata(rdata)
  );

  always #5 clock = ~clock;

  // Behavioural model state
  bit [7:0] m_mask = 8'hFF, m_pend = 8'h00, m_isr = 8'h00;
  bit       m_wait = 1'b0;
  int       m_gap = 0;
  bit       m_irq = 1'b0;
  int       m_vec = 0;

  int vectors = 0, miscompares = 0;
  bit chk_en = 1'b0;

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  function logic [7:0] m_rdata(input logic [15:0] a);
    int off;
    off = int'(a) - int'(BASE);
    if (off < 0 || off > 3) return 8'hFF;
    case (off)
      0:       return m_mask;
      1:       return m_pend;
      2:       return m_isr;
      default: return {m_wait, (m_gap != 0), 2'b00, 4'(m_vec)};
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin : model
    int lo, win, off;
    bit issue;
    bit [7:0] np, ni, nm;
    if (reset) begin
      m_mask = 8'hFF; m_pend = 8'h00; m_isr = 8'h00;
      m_wait = 1'b0; m_gap = 0; m_irq = 1'b0; m_vec = 0;
    end else begin
      lo  = lowest(m_isr);
      win = -1;
      for (int i = NSRC - 1; i >= 0; i--)
        if (m_pend[i] && !m_mask[i] && i < lo) win = i;
      issue = !m_wait && iff1 && (m_gap == 0) && (win >= 0);
      off = int'(address) - int'(BASE);
      np = m_pend; ni = m_isr; nm = m_mask;
      if (port_we && off >= 0 && off < 4) begin
        case (off)
          0: for (int i = 0; i < NSRC; i++) nm[i] = out[i];
          1: np = np & ~out;
          2: if (lo < 8) ni[lo] = 1'b0;
          default: ;
        endcase
      end
      if (issue) begin
        m_irq = !m_irq;
        m_vec = win + 1;
        np[win] = 1'b0;
        ni[win] = 1'b1;
        m_wait = 1'b1;
      end else if (m_wait) begin
        if (!iff1) begin
          m_wait = 1'b0;
          m_gap = GAP;
        end
      end else if (m_gap > 0) begin
        m_gap = m_gap - 1;
      end
      np = np | 8'(req);
      m_pend = np; m_isr = ni; m_mask = nm;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      vectors++;
      if (irq !== m_irq || vector !== 4'(m_vec) || rdata !== m_rdata(address)) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t irq=%0d exp %0d vector=%0d exp %0d rdata=%h exp %h addr=%h",
                 $time, irq, m_irq, vector, m_vec, rdata, m_rdata(address), address);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_rd(input string name, input logic [15:0] a, input logic [7:0] exp);
    address = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address = a; out = d; port_we = 1'b1;
    cyc();
    port_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] r);
    req = NSRC'(r);
    cyc();
    req = '0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_vector", {4'b0, vector}, 8'h00);
    chk_rd("rst_mask", BASE, 8'hFF);
    chk_rd("rst_pend", BASE + 16'd1, 8'h00);
    chk_rd("rst_isr", BASE + 16'd2, 8'h00);
    chk_rd("unaddressed", 16'h00FE, 8'hFF);

    // Single issue, latency, then gap after acceptance
    iff1 = 1'b1;
    wr(BASE, 8'h00);
    pulse(8'h01);
    chk_rd("pend_visible", BASE + 16'd1, 8'h01);
    cyc();
    chk("t2_irq", {7'b0, irq}, 8'h01);
    chk("t2_vector", {4'b0, vector}, 8'h01);
    chk_rd("t2_isr", BASE + 16'd2, 8'h01);
    chk_rd("t2_pend", BASE + 16'd1, 8'h00);
    chk_rd("t2_stat_wait", BASE + 16'd3, 8'h81);
    iff1 = 1'b0;
    cyc();
    chk_rd("t2_stat_gap", BASE + 16'd3, 8'h41);
    repeat (3) cyc();
    chk_rd("t2_stat_gap_last", BASE + 16'd3, 8'h41);
    cyc();
    chk_rd("t2_stat_gap_done", BASE + 16'd3, 8'h01);
    wr(BASE + 16'd2, 8'h00);
    chk_rd("t2_eoi", BASE + 16'd2, 8'h00);

    // Priority and in-service nesting
    iff1 = 1'b1;
    pulse(8'h06);
    cyc();
    chk("t3_vector", {4'b0, vector}, 8'h02);
    chk("t3_irq", {7'b0, irq}, 8'h00);
    chk_rd("t3_isr", BASE + 16'd2, 8'h02);
    chk_rd("t3_pend", BASE + 16'd1, 8'h04);
    iff1 = 1'b0;
    cyc();
    iff1 = 1'b1;
    repeat (6) cyc();
    chk("t3_blocked_irq", {7'b0, irq}, 8'h00);
    chk("t3_blocked_vec", {4'b0, vector}, 8'h02);
    wr(BASE + 16'd2, 8'h00);
    chk_rd("t3_eoi", BASE + 16'd2, 8'h00);
    cyc();
    chk("t3_vector2", {4'b0, vector}, 8'h03);
    chk("t3_irq2", {7'b0, irq}, 8'h01);
    iff1 = 1'b0;
    cyc();
    wr(BASE + 16'd2, 8'h00);
    iff1 = 1'b1;
    repeat (5) cyc();

    // Masked source waits, issued once unmasked (old mask used on the write edge)
    wr(BASE, 8'hFE);
    pulse(8'h08);
    cyc();
    chk("t4_no_toggle", {7'b0, irq}, 8'h01);
    chk_rd("t4_pend", BASE + 16'd1, 8'h08);
    wr(BASE, 8'h00);
    chk("t4_old_mask", {7'b0, irq}, 8'h01);
    cyc();
    chk("t4_vector", {4'b0, vector}, 8'h04);
    chk("t4_irq", {7'b0, irq}, 8'h00);
    iff1 = 1'b0;
    cyc();
    wr(BASE + 16'd2, 8'h00);
    iff1 = 1'b1;
    repeat (5) cyc();

    // Request beats same-cycle clear; asynchronous reset in WAIT
    iff1 = 1'b0;
    req = NSRC'(8'h20); address = BASE + 16'd1; out = 8'h20; port_we = 1'b1;
    cyc();
    req = '0; port_we = 1'b0;
    chk_rd("t5_req_wins", BASE + 16'd1, 8'h20);
    iff1 = 1'b1;
    cyc();
    chk("t5_vector", {4'b0, vector}, 8'h06);
    chk_rd("t5_stat", BASE + 16'd3, 8'h86);
    pulse(8'h80);
    chk_rd("t5_pend_wait", BASE + 16'd1, 8'h80);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_irq", {7'b0, irq}, 8'h00);
    chk("t5_async_vector", {4'b0, vector}, 8'h00);
    chk_rd("t5_async_pend", BASE + 16'd1, 8'h00);
    chk_rd("t5_async_mask", BASE, 8'hFF);
    cyc();
    reset = 1'b0;
    cyc();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      req     = NSRC'(8'($urandom) & 8'($urandom) & 8'($urandom));
      iff1    = ($urandom_range(0, 9) < 7);
      port_we = ($urandom_range(0, 4) == 0);
      port_rd = $urandom_range(0, 1) == 1;
      address = BASE - 16'd1 + 16'($urandom_range(0, 5));
      out     = 8'($urandom) & 8'($urandom);
      reset   = ($urandom_range(0, 399) == 0);
      cyc();
    end
    req = '0; port_we = 1'b0; reset = 1'b0; iff1 = 1'b0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
